// File: rtl/bin_down_timer_if.sv
// Control/status bundle for bin_down_timer. The wrap_cnt status field exists only
// when BIN_DOWN_TIMER_WRAP_CNT_EN is defined.
interface bin_down_timer_if #(
  parameter int N = 8
);
  logic         load;
  logic [N-1:0] din;
  logic         start;
  logic         stop;
  logic         periodic;
  logic         en;
  logic [N-1:0] q;
  logic         min_tick;
  logic         busy;
  logic         done;
  logic [1:0]   state_dbg;
`ifdef BIN_DOWN_TIMER_WRAP_CNT_EN
  logic [7:0]   wrap_cnt;

  modport master (
    output load, din, start, stop, periodic, en,
    input  q, min_tick, busy, done, state_dbg, wrap_cnt
  );
  modport slave (
    input  load, din, start, stop, periodic, en,
    output q, min_tick, busy, done, state_dbg, wrap_cnt
  );
`else
  modport master (
    output load, din, start, stop, periodic, en,
    input  q, min_tick, busy, done, state_dbg
  );
  modport slave (
    input  load, din, start, stop, periodic, en,
    output q, min_tick, busy, done, state_dbg
  );
`endif
endinterface

// File: rtl/bin_down_timer.sv
// Loadable N-bit down-counter timer with one-shot/periodic modes and count enable.
// Define BIN_DOWN_TIMER_WRAP_CNT_EN to add the saturating 8-bit expiry counter wrap_cnt.
module bin_down_timer #(
  parameter int N = 8
) (
  input  logic            clk,
  input  logic            reset,
  bin_down_timer_if.slave tmr
);
  // Control inputs are single-cycle pulses sampled on the rising edge; there is no
  // back-pressure. Priority each cycle: reset > stop > load > start > counting.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic [N-1:0] period_q, period_d;
  logic         tick;
  logic         start_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    period_d = period_q;
    tick     = 1'b0;
    start_ok = 1'b0;
    if (tmr.stop) begin
      state_d = IDLE;
    end else if (tmr.load) begin
      period_d = tmr.din;
      q_d      = tmr.din;
      if (state_q == DONE) state_d = IDLE;
    end else if (tmr.start && (state_q != RUN)) begin
      start_ok = 1'b1;
      q_d      = period_q;
      state_d  = RUN;
    end else if ((state_q == RUN) && tmr.en) begin
      // A start pulse while running falls through to here and is ignored.
      if (q_q != '0) begin
        q_d = q_q - N'(1);
      end else begin
        tick = 1'b1;
        if (tmr.periodic) q_d = period_q;
        else              state_d = DONE;
      end
    end
  end

  assign tmr.q         = q_q;
  assign tmr.min_tick  = tick;
  assign tmr.busy      = (state_q == RUN);
  assign tmr.done      = (state_q == DONE);
  assign tmr.state_dbg = state_q;

`ifdef BIN_DOWN_TIMER_WRAP_CNT_EN
  logic [7:0] wrap_q, wrap_d;

  always_comb begin
    wrap_d = wrap_q;
    if (tmr.stop)                     wrap_d = wrap_q;
    else if (tmr.load || start_ok)    wrap_d = '0;
    else if (tick && (wrap_q != 8'hff)) wrap_d = wrap_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wrap_q <= '0;
    else       wrap_q <= wrap_d;
  end

  assign tmr.wrap_cnt = wrap_q;
`endif
endmodule
